// File: rtl/serdesphy_ana_rx_signal_qualifier.sv
// RX signal qualifier: debounces signal detect, checks transition density per window,
// gates serial data to the CDR. Optional sticky LOS flag under SERDESPHY_RX_LOS_STICKY_EN.
module serdesphy_ana_rx_signal_qualifier #(
  parameter int ASSERT_CNT   = 16,
  parameter int DEASSERT_CNT = 32,
  parameter int WIN_LEN      = 64,
  parameter int MIN_TRANS    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       serial_data_in,
  input  logic       signal_detected_in,
`ifdef SERDESPHY_RX_LOS_STICKY_EN
  input  logic       los_clr,
  output logic       los_sticky,
`endif
  output logic       serial_data_out,
  output logic       data_valid,
  output logic       los,
  output logic [1:0] state,
  output logic [7:0] trans_last
);

  typedef enum logic [1:0] {
    ST_LOS   = 2'd0,
    ST_ACQ   = 2'd1,
    ST_VALID = 2'd2
  } state_e;

  localparam logic [7:0] ASSERT_M1   = 8'(ASSERT_CNT - 1);
  localparam logic [7:0] DEASSERT_M1 = 8'(DEASSERT_CNT - 1);
  localparam logic [7:0] WIN_M1      = 8'(WIN_LEN - 1);
  localparam logic [8:0] MIN_T       = 9'(MIN_TRANS);

  state_e     state_q, state_d;
  logic [7:0] det_cnt_q, det_cnt_d;
  logic [7:0] win_cnt_q, win_cnt_d;
  logic [7:0] trans_cnt_q, trans_cnt_d;
  logic [7:0] miss_cnt_q, miss_cnt_d;
  logic [7:0] trans_last_q, trans_last_d;
  logic       prev_q;
  logic       dout_q;
  logic       dv_q;

  logic       trans;
  logic       win_end;
  logic [8:0] win_total;
  logic       win_ok;

  always_comb begin
    trans     = serial_data_in ^ prev_q;
    win_end   = (win_cnt_q == WIN_M1);
    win_total = {1'b0, trans_cnt_q} + {8'd0, trans};
    win_ok    = (win_total >= MIN_T);
  end

  always_comb begin
    state_d      = state_q;
    det_cnt_d    = det_cnt_q;
    win_cnt_d    = win_cnt_q;
    trans_cnt_d  = trans_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    trans_last_d = trans_last_q;

    case (state_q)
      ST_LOS: begin
        win_cnt_d   = '0;
        trans_cnt_d = '0;
        miss_cnt_d  = '0;
        if (signal_detected_in) begin
          if (det_cnt_q == ASSERT_M1) begin
            state_d   = ST_ACQ;
            det_cnt_d = '0;
          end else begin
            det_cnt_d = det_cnt_q + 8'd1;
          end
        end else begin
          det_cnt_d = '0;
        end
      end

      ST_ACQ, ST_VALID: begin
        det_cnt_d = '0;
        // Window runs identically in both states so it spans ACQ->VALID untouched.
        if (win_end) begin
          trans_last_d = (win_total > 9'd255) ? 8'hFF : win_total[7:0];
          win_cnt_d    = '0;
          trans_cnt_d  = '0;
        end else begin
          win_cnt_d    = win_cnt_q + 8'd1;
          trans_cnt_d  = trans_cnt_q + {7'd0, trans};
        end

        if (state_q == ST_ACQ) begin
          miss_cnt_d = '0;
          if (!signal_detected_in) begin
            state_d     = ST_LOS;
            win_cnt_d   = '0;
            trans_cnt_d = '0;
          end else if (win_end && win_ok) begin
            state_d = ST_VALID;
          end
        end else begin
          miss_cnt_d = signal_detected_in ? 8'd0 : miss_cnt_q + 8'd1;
          // Loss of detect outranks a same-cycle density failure.
          if (!signal_detected_in && (miss_cnt_q == DEASSERT_M1)) begin
            state_d     = ST_LOS;
            win_cnt_d   = '0;
            trans_cnt_d = '0;
            miss_cnt_d  = '0;
          end else if (win_end && !win_ok) begin
            state_d    = ST_ACQ;
            miss_cnt_d = '0;
          end
        end
      end

      default: begin
        state_d     = ST_LOS;
        det_cnt_d   = '0;
        win_cnt_d   = '0;
        trans_cnt_d = '0;
        miss_cnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      state_q     <= ST_LOS;
      det_cnt_q   <= '0;
      win_cnt_q   <= '0;
      trans_cnt_q <= '0;
      miss_cnt_q  <= '0;
      prev_q      <= 1'b0;
      dout_q      <= 1'b0;
      dv_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      det_cnt_q   <= det_cnt_d;
      win_cnt_q   <= win_cnt_d;
      trans_cnt_q <= trans_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      prev_q      <= serial_data_in;
      dout_q      <= (state_q == ST_VALID) & serial_data_in;
      dv_q        <= (state_q == ST_VALID);
    end
  end

  // Last window total survives a disable; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst)         trans_last_q <= '0;
    else if (enable) trans_last_q <= trans_last_d;
  end

`ifdef SERDESPHY_RX_LOS_STICKY_EN
  logic sticky_q;
  logic sticky_set;

  always_comb sticky_set = enable && (state_q == ST_VALID) && (state_d != ST_VALID);

  always_ff @(posedge clk) begin
    if (rst)             sticky_q <= 1'b0;
    else if (sticky_set) sticky_q <= 1'b1;
    else if (los_clr)    sticky_q <= 1'b0;
  end

  assign los_sticky = sticky_q;
`endif

  assign serial_data_out = dout_q;
  assign data_valid      = dv_q;
  assign los             = (state_q == ST_LOS);
  assign state           = state_q;
  assign trans_last      = trans_last_q;

endmodule

// File: doc/serdesphy_ana_rx_signal_qualifier.md
# serdesphy_ana_rx_signal_qualifier

Qualifies the receiver's raw serial stream before it reaches the CDR/deserializer. It sits directly downstream of the RX differential receiver and consumes its `serial_data` and `signal_detected` outputs. It debounces signal detect, checks transition density over fixed windows, and gates the data stream. It reports loss-of-signal (LOS) and a registered data-valid qualifier to the PCS and CSR.

## Interface
Parameters:
- `ASSERT_CNT`, default 16: consecutive detect-high cycles needed to leave LOS. Range 2..255.
- `DEASSERT_CNT`, default 32: consecutive detect-low cycles in VALID that force LOS. Range 2..255.
- `WIN_LEN`, default 64: transition-density window length in cycles. Range 8..255.
- `MIN_TRANS`, default 8: minimum transitions per window to qualify. Range 1..`WIN_LEN`.

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1: system clock, 240 MHz; the only clock.
- `rst` input 1: synchronous active-high reset.
- `enable` input 1: block enable; low acts as a synchronous clear.
- `serial_data_in` input 1: receiver `serial_data`.
- `signal_detected_in` input 1: receiver `signal_detected`.
- `serial_data_out` output 1: gated, registered data to the CDR.
- `data_valid` output 1: qualifier aligned with `serial_data_out`.
- `los` output 1: loss of signal.
- `state` output 2: current state, for CSR/debug.
- `trans_last` output 8: transition count of the last completed window.
- `los_clr` input 1: clears the sticky flag; present only with the macro.
- `los_sticky` output 1: sticky LOS event flag; present only with the macro.

## Operation
- States: LOS=2'd0, ACQ=2'd1, VALID=2'd2. 2'd3 is unused and must recover to LOS on the next edge.
- Transition detect:
  - `prev_data` registers `serial_data_in` every enabled cycle.
  - `trans = serial_data_in ^ prev_data`.
- `det_cnt` (LOS state):
  - Increments while `signal_detected_in`=1 and clears on 0.
  - When `det_cnt`==`ASSERT_CNT`-1 and detect=1: go to ACQ, clear `det_cnt`, `win_cnt`, `trans_cnt`.
- Window logic (ACQ and VALID):
  - `win_cnt` counts 0..`WIN_LEN`-1.
  - `trans_cnt` accumulates `trans`.
  - At `win_cnt`==`WIN_LEN`-1 (window end), the window total is `trans_cnt`+`trans`. It is written to `trans_last`, saturating at 255.
  - At window end, `trans_cnt` and `win_cnt` clear.
- ACQ exits:
  - Detect=0 on any cycle: go to LOS next edge and clear all counters.
  - Window end with total >= `MIN_TRANS`: go to VALID.
  - Window end with total < `MIN_TRANS`: stay in ACQ and start a new window.
- VALID:
  - `miss_cnt` increments on detect=0 and clears on detect=1.
  - `miss_cnt`==`DEASSERT_CNT`-1 with detect=0: go to LOS.
  - Window end with total < `MIN_TRANS`: go to ACQ; the window restarts from 0.
  - If both happen on the same cycle, LOS wins.
- Windows run continuously across ACQ→VALID; `win_cnt` does not reset on that transition.
- Output gating, on every edge:
  - State==VALID: `serial_data_out`<=`serial_data_in` and `data_valid`<=1.
  - Any other state: both <=0.
- `los` = (state==LOS), decoded directly from the state flop.
- `enable`=0 or `rst`=1:
  - state=LOS; all counters, `prev_data`, `serial_data_out` and `data_valid` are 0.
  - `rst` also clears `trans_last`; `enable`=0 holds `trans_last`.

## Timing
- Reset values:
  - `los`=1, `data_valid`=0, `serial_data_out`=0, `state`=0, `trans_last`=0.
  - `los_sticky`=0 when the macro is defined.
- Data latency: 1 cycle from `serial_data_in` to `serial_data_out`.
- `data_valid` lags the state by 1 cycle. The sample taken on the edge that leaves VALID still carries `data_valid`=1.
- LOS→ACQ: if detect is first sampled high at edge k and stays high, the state is ACQ after edge k+`ASSERT_CNT`-1.
- Best-case LOS→VALID: `ASSERT_CNT`+`WIN_LEN` edges.
- VALID→LOS: exactly `DEASSERT_CNT` consecutive detect-low samples.
- A reset or disable asserted mid-operation takes effect on the next edge, with no intermediate states.

## Configuration
- Macro: `SERDESPHY_RX_LOS_STICKY_EN`.
- Defined:
  - `los_sticky` sets on any exit from VALID, to ACQ or to LOS.
  - `los_clr`=1 clears it.
  - Set has priority over a same-cycle clear.
  - Cleared by `rst`; unaffected by `enable`.
- Undefined: the `los_clr` and `los_sticky` ports and their logic are absent. All other behaviour is identical.

## Test plan
Default parameters throughout.

1. Reset: assert `rst` for 2 cycles with random inputs → `los`=1, `state`=0, `data_valid`=0, `serial_data_out`=0, `trans_last`=0.
2. Acquisition: detect=1 with data 1010… → `state`=1 after 16 edges, `state`=2 after 64 more, `trans_last`≥63. `data_valid`=1 one cycle later, and `serial_data_out` equals the input delayed by 1.
3. Detect glitches: 15 cycles high, 1 low, repeated 20 times → `state` stays 0 and `los`=1 throughout.
4. Miss counter in VALID:
   - Detect low for 31 cycles, then high → remains VALID.
   - Later, low for 32 cycles → `state`=0 on the 32nd edge, `los`=1, `data_valid`=0 one cycle later.
5. Density failure in VALID: hold data at 1 for 2 windows → `state`=1 at the end of the first fully constant window, `trans_last`=0, `data_valid`=0. Resuming toggling returns the state to 2 after one window.
6. Sticky flag (macro defined):
   - VALID→LOS sets `los_sticky`=1, which survives reacquisition.
   - `los_clr` pulse → 0.
   - `rst` mid-ACQ → all outputs return to reset values on the next edge.
